// File: rtl/eai_mult_seq_pkg.sv
// Shared EAI definitions: sequencer state encoding and the MULT CSR address map.
// Imported by the sequencer, the CSR unit and the MAC datapath.
package eai_mult_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam int OUTST_W = 4;

  localparam logic [11:0] CSR_MULT_LHS_BASE   = 12'h100;
  localparam logic [11:0] CSR_MULT_RHS_BASE   = 12'h104;
  localparam logic [11:0] CSR_MULT_DST_BASE   = 12'h108;
  localparam logic [11:0] CSR_MULT_BIAS_BASE  = 12'h10C;
  localparam logic [11:0] CSR_MULT_M          = 12'h110;
  localparam logic [11:0] CSR_MULT_K          = 12'h114;
  localparam logic [11:0] CSR_MULT_N          = 12'h118;
  localparam logic [11:0] CSR_MULT_LHS_STRIDE = 12'h11C;
  localparam logic [11:0] CSR_MULT_RHS_STRIDE = 12'h120;
  localparam logic [11:0] CSR_MULT_DST_STRIDE = 12'h124;

endpackage

// File: rtl/eai_outst_cnt.sv
// Saturating up/down count of in-flight jobs; registered outputs, one-cycle update.
// inc while full and dec while empty are dropped; inc together with dec holds the count.
module eai_outst_cnt
  import eai_mult_seq_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               dec,
  output logic [OUTST_W-1:0] cnt,
  output logic               full,
  output logic               empty
);

  logic [OUTST_W-1:0] cnt_q, cnt_d;

  assign full  = (int'(cnt_q) >= MAX);
  assign empty = (cnt_q == '0);
  assign cnt   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !full) begin
      cnt_d = cnt_q + OUTST_W'(1);
    end else if (dec && !inc && !empty) begin
      cnt_d = cnt_q - OUTST_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/eai_mult_seq.sv
// Row-major C[m][n] job sequencer: first job two cycles after start, then one per cycle.
// Job fields hold while job_valid & !job_ready; issue pauses at MAX_OUTST in-flight jobs.
module eai_mult_seq
  import eai_mult_seq_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [REG_WIDTH-1:0] lhs_base,
  input  logic [REG_WIDTH-1:0] rhs_base,
  input  logic [REG_WIDTH-1:0] dst_base,
  input  logic [REG_WIDTH-1:0] bias_base,
  input  logic [REG_WIDTH-1:0] m,
  input  logic [REG_WIDTH-1:0] k,
  input  logic [REG_WIDTH-1:0] n,
  input  logic [REG_WIDTH-1:0] lhs_row_stride_b,
  input  logic [REG_WIDTH-1:0] rhs_col_stride_b,
  input  logic [REG_WIDTH-1:0] dst_row_stride_b,
  output logic                 job_valid,
  input  logic                 job_ready,
  output logic [REG_WIDTH-1:0] job_lhs_addr,
  output logic [REG_WIDTH-1:0] job_rhs_addr,
  output logic [REG_WIDTH-1:0] job_dst_addr,
  output logic [REG_WIDTH-1:0] job_bias_addr,
  output logic [REG_WIDTH-1:0] job_len,
  output logic                 job_bias_en,
  output logic                 job_last,
  input  logic                 cmpl_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err_zero
);

  localparam logic [REG_WIDTH-1:0] ONE  = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] FOUR = REG_WIDTH'(4);

  seq_state_e state_q, state_d;

  logic [REG_WIDTH-1:0] lhs_base_q, rhs_base_q, dst_base_q, bias_base_q;
  logic [REG_WIDTH-1:0] m_q, k_q, n_q;
  logic [REG_WIDTH-1:0] lhs_stride_q, rhs_stride_q, dst_stride_q;
  logic [REG_WIDTH-1:0] r_q, c_q;
  logic [REG_WIDTH-1:0] lhs_acc_q, rhs_acc_q, dst_row_q, dst_acc_q, bias_acc_q;
  logic                 err_zero_q;

  logic               snap_ld, acc_ld, err_set;
  logic               hs, c_wrap, last_job, dims_zero;
  logic [OUTST_W-1:0] outst_cnt;
  logic               outst_full, outst_empty;

  assign hs        = job_valid & job_ready;
  assign c_wrap    = (c_q == n_q - ONE);
  assign last_job  = (r_q == m_q - ONE) & c_wrap;
  assign dims_zero = (m_q == '0) | (n_q == '0) | (k_q == '0);

  eai_outst_cnt #(
    .MAX (MAX_OUTST)
  ) u_outst (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hs),
    .dec   (cmpl_valid & ~outst_empty),
    .cnt   (outst_cnt),
    .full  (outst_full),
    .empty (outst_empty)
  );

  always_comb begin
    state_d = state_q;
    snap_ld = 1'b0;
    acc_ld  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_ld = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (dims_zero) begin
          err_set = 1'b1;
          state_d = ST_DONE;
        end else begin
          acc_ld  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (hs && last_job) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outst_cnt == '0) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lhs_base_q   <= '0;
      rhs_base_q   <= '0;
      dst_base_q   <= '0;
      bias_base_q  <= '0;
      m_q          <= '0;
      k_q          <= '0;
      n_q          <= '0;
      lhs_stride_q <= '0;
      rhs_stride_q <= '0;
      dst_stride_q <= '0;
      r_q          <= '0;
      c_q          <= '0;
      lhs_acc_q    <= '0;
      rhs_acc_q    <= '0;
      dst_row_q    <= '0;
      dst_acc_q    <= '0;
      bias_acc_q   <= '0;
      err_zero_q   <= 1'b0;
    end else begin
      if (snap_ld) begin
        lhs_base_q   <= lhs_base;
        rhs_base_q   <= rhs_base;
        dst_base_q   <= dst_base;
        bias_base_q  <= bias_base;
        m_q          <= m;
        k_q          <= k;
        n_q          <= n;
        lhs_stride_q <= lhs_row_stride_b;
        rhs_stride_q <= rhs_col_stride_b;
        dst_stride_q <= dst_row_stride_b;
        r_q          <= '0;
        c_q          <= '0;
        err_zero_q   <= 1'b0;
      end
      if (err_set) err_zero_q <= 1'b1;
      if (acc_ld) begin
        lhs_acc_q  <= lhs_base_q;
        rhs_acc_q  <= rhs_base_q;
        dst_row_q  <= dst_base_q;
        dst_acc_q  <= dst_base_q;
        bias_acc_q <= bias_base_q;
      end else if (state_q == ST_ISSUE && hs) begin
        if (c_wrap) begin
          // Row wrap: column-indexed pointers restart, row pointers step.
          c_q        <= '0;
          r_q        <= r_q + ONE;
          rhs_acc_q  <= rhs_base_q;
          bias_acc_q <= bias_base_q;
          lhs_acc_q  <= lhs_acc_q + lhs_stride_q;
          dst_row_q  <= dst_row_q + dst_stride_q;
          dst_acc_q  <= dst_row_q + dst_stride_q;
        end else begin
          c_q        <= c_q + ONE;
          rhs_acc_q  <= rhs_acc_q + rhs_stride_q;
          dst_acc_q  <= dst_acc_q + ONE;
          bias_acc_q <= bias_acc_q + FOUR;
        end
      end
    end
  end

  assign job_valid     = (state_q == ST_ISSUE) & ~outst_full;
  assign job_lhs_addr  = lhs_acc_q;
  assign job_rhs_addr  = rhs_acc_q;
  assign job_dst_addr  = dst_acc_q;
  assign job_bias_addr = bias_acc_q;
  assign job_len       = k_q;
  assign job_bias_en   = (bias_base_q != '0);
  assign job_last      = (state_q == ST_ISSUE) & last_job;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign err_zero      = err_zero_q;

endmodule

// File: tb/tb_eai_mult_seq.sv
module tb_eai_mult_seq;
  localparam int W    = 32;
  localparam int MAXO = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] lhs_base_i, rhs_base_i, dst_base_i, bias_base_i;
  logic [W-1:0] m_i, k_i, n_i, ls_i, rs_i, ds_i;
  logic         job_valid, job_ready;
  logic [W-1:0] job_lhs_addr, job_rhs_addr, job_dst_addr, job_bias_addr, job_len;
  logic         job_bias_en, job_last, cmpl_valid, busy, done, err_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  eai_mult_seq #(.REG_WIDTH(W), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .lhs_base(lhs_base_i), .rhs_base(rhs_base_i), .dst_base(dst_base_i), .bias_base(bias_base_i),
    .m(m_i), .k(k_i), .n(n_i),
    .lhs_row_stride_b(ls_i), .rhs_col_stride_b(rs_i), .dst_row_stride_b(ds_i),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_lhs_addr(job_lhs_addr), .job_rhs_addr(job_rhs_addr),
    .job_dst_addr(job_dst_addr), .job_bias_addr(job_bias_addr),
    .job_len(job_len), .job_bias_en(job_bias_en), .job_last(job_last),
    .cmpl_valid(cmpl_valid), .busy(busy), .done(done), .err_zero(err_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_csr(input logic [W-1:0] mm, nn, kk, lb, ls, rb, rs, db, ds, bb);
    m_i = mm; n_i = nn; k_i = kk;
    lhs_base_i = lb; ls_i = ls; rhs_base_i = rb; rs_i = rs;
    dst_base_i = db; ds_i = ds; bias_base_i = bb;
  endtask

  // Drives one full operation and checks every job against C[r][c] addresses
  // computed directly from the matrix geometry.
  task automatic run_stream(input int mm, nn, kk,
                            input logic [W-1:0] lb, ls, rb, rs, db, ds, bb,
                            input int ready_pct, lat, input bit perturb, input string tag);
    int idx = 0, done_cnt = 0, cyc = 0, outst = 0, r, c;
    int due[$];
    bit stalled = 0, seen_done = 0;
    logic [4*W:0] held, now_v;
    logic [W-1:0] e_lhs, e_rhs, e_dst, e_bias;
    set_csr(W'(mm), W'(nn), W'(kk), lb, ls, rb, rs, db, ds, bb);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (err_zero !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start: err_zero=%b busy=%b want 0/1", tag, err_zero, busy);
    end
    while (cyc < 3000) begin
      cmpl_valid = 1'b0;
      if (due.size() > 0 && due[0] <= cyc) begin
        cmpl_valid = 1'b1;
        void'(due.pop_front());
      end
      job_ready = ($urandom_range(99) < ready_pct);
      if (perturb && cyc == 3) begin
        m_i = 5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (seen_done) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s busy_after_done: got %b want 0", tag, busy);
        end
        break;
      end
      if (idx < mm * nn) begin
        n_cmp++;
        if (job_valid !== (cyc >= 1 && outst < MAXO)) begin
          n_fail++;
          $display("FAIL %s valid_gate cyc%0d: got %b want %b (outst %0d)",
                   tag, cyc, job_valid, (cyc >= 1 && outst < MAXO), outst);
        end
      end
      now_v = {job_valid, job_lhs_addr, job_rhs_addr, job_dst_addr, job_bias_addr};
      if (stalled) begin
        n_cmp++;
        if (now_v !== held || job_last !== held[4*W]) begin
          if (now_v !== held) begin
            n_fail++;
            $display("FAIL %s stall_hold cyc%0d: got %h want %h", tag, cyc, now_v, held);
          end
        end
      end
      if (job_valid && job_ready) begin
        r = idx / nn; c = idx % nn;
        e_lhs  = lb + ls * W'(r);
        e_rhs  = rb + rs * W'(c);
        e_dst  = db + ds * W'(r) + W'(c);
        e_bias = bb + W'(4 * c);
        n_cmp++;
        if ({job_lhs_addr, job_rhs_addr, job_dst_addr, job_bias_addr} !== {e_lhs, e_rhs, e_dst, e_bias}) begin
          n_fail++;
          $display("FAIL %s addr job%0d: got %h/%h/%h/%h want %h/%h/%h/%h", tag, idx,
                   job_lhs_addr, job_rhs_addr, job_dst_addr, job_bias_addr, e_lhs, e_rhs, e_dst, e_bias);
        end
        n_cmp++;
        if (job_last !== (idx == mm * nn - 1) || job_len !== W'(kk) || job_bias_en !== (bb != 0)) begin
          n_fail++;
          $display("FAIL %s ctl job%0d: last=%b len=%0d bias_en=%b want %b/%0d/%b", tag, idx,
                   job_last, job_len, job_bias_en, (idx == mm * nn - 1), kk, (bb != 0));
        end
        due.push_back(cyc + lat);
        idx++;
        outst++;
      end
      if (cmpl_valid) outst--;
      stalled = job_valid && !job_ready;
      held = now_v;
      if (done) begin
        done_cnt++;
        seen_done = 1;
        n_cmp++;
        if (outst != 0 || idx != mm * nn) begin
          n_fail++;
          $display("FAIL %s early_done: outst %0d jobs %0d want 0/%0d", tag, outst, idx, mm * nn);
        end
      end
      tick();
      cyc++;
    end
    cmpl_valid = 1'b0; job_ready = 1'b0; start = 1'b0;
    n_cmp++;
    if (idx != mm * nn || done_cnt != 1 || cyc >= 3000) begin
      n_fail++;
      $display("FAIL %s totals: jobs %0d done %0d cyc %0d want %0d/1/<3000", tag, idx, done_cnt, cyc, mm * nn);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; job_ready = 1'b0; cmpl_valid = 1'b0;
    set_csr('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    tick(); tick();
    n_cmp++;
    if ({job_valid, busy, done, err_zero, job_last, job_bias_en, job_lhs_addr, job_rhs_addr,
         job_dst_addr, job_bias_addr, job_len} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b busy=%b done=%b err=%b lhs=%h len=%h want all 0",
               job_valid, busy, done, err_zero, job_lhs_addr, job_len);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    run_stream(2, 3, 8, 32'h1000, 16, 32'h2000, 8, 32'h3000, 4, 32'h4000, 100, 2, 0, "basic");
  endtask

  task automatic test_outst_limit();
    int hs = 0, o, cyc;
    bit got_done = 0;
    set_csr(1, 8, 4, 32'h100, 0, 32'h200, 2, 32'h300, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    job_ready = 1'b1; cmpl_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (job_valid && job_ready) hs++;
      tick();
    end
    n_cmp++;
    if (hs != MAXO || job_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL outst_cap: issued %0d valid %b want %0d/0", hs, job_valid, MAXO);
    end
    cmpl_valid = 1'b1; tick(); cmpl_valid = 1'b0;
    n_cmp++;
    if (job_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL outst_unblock: valid %b want 1", job_valid);
    end
    if (job_valid) hs++;
    tick();
    n_cmp++;
    if (job_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL outst_reblock: valid %b want 0", job_valid);
    end
    o = MAXO;
    for (cyc = 0; cyc < 100 && !got_done; cyc++) begin
      cmpl_valid = (o > 0);
      if (job_valid && job_ready) begin hs++; o++; end
      if (cmpl_valid) o--;
      if (done) got_done = 1;
      tick();
    end
    cmpl_valid = 1'b0; job_ready = 1'b0;
    n_cmp++;
    if (hs != 8 || !got_done) begin
      n_fail++;
      $display("FAIL outst_total: issued %0d done %b want 8/1", hs, got_done);
    end
  endtask

  task automatic test_back_to_back();
    run_stream(3, 3, 5, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               50, $urandom_range(5, 1), 0, "bp3x3");
    for (int t = 0; t < 4; t++) begin
      run_stream($urandom_range(4, 1), $urandom_range(5, 1), $urandom_range(9, 1),
                 $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 (t == 0) ? 32'h0 : $urandom, $urandom_range(100, 30), $urandom_range(8, 1), 0, "rand");
    end
  endtask

  task automatic test_zero_dim();
    set_csr(3, 3, 0, 32'h1000, 16, 32'h2000, 8, 32'h3000, 4, 32'h4000);
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || job_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_check: busy=%b valid=%b done=%b want 1/0/0", busy, job_valid, done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || err_zero !== 1'b1 || job_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: done=%b err=%b valid=%b want 1/1/0", done, err_zero, job_valid);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || err_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_after: busy=%b err=%b want 0/1", busy, err_zero);
    end
    run_stream(1, 2, 3, 32'h10, 4, 32'h20, 4, 32'h30, 4, 32'h40, 100, 1, 0, "after_zero");
  endtask

  task automatic test_csr_change();
    run_stream(2, 3, 4, 32'h500, 32, 32'h600, 16, 32'h700, 8, 32'h800, 100, 3, 1, "csr_change");
  endtask

  task automatic test_reset_mid();
    int hs = 0;
    set_csr(1, 8, 4, 32'h1000, 16, 32'h2000, 8, 32'h3000, 4, 32'h4000);
    start = 1'b1; tick(); start = 1'b0;
    job_ready = 1'b1;
    for (int i = 0; i < 20 && hs < 3; i++) begin
      if (job_valid && job_ready) hs++;
      tick();
    end
    job_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (hs != 3 || {job_valid, busy, done, err_zero, job_last, job_bias_en, job_lhs_addr,
                    job_rhs_addr, job_dst_addr, job_bias_addr, job_len} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: issued %0d valid=%b busy=%b lhs=%h bias=%h want 3 and all 0",
               hs, job_valid, busy, job_lhs_addr, job_bias_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    run_stream(1, 6, 2, 32'h90, 8, 32'hA0, 8, 32'hB0, 8, 32'hC0, 100, 8, 0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_outst_limit();
    test_back_to_back();
    test_zero_dim();
    test_csr_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
